// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_ctrl_pkg;

    localparam int unsigned IMEM_AW        = 6;
    localparam int unsigned IMEM_DEPTH     = 2 ** IMEM_AW;
    localparam int unsigned BYTES_PER_WORD = 4;

    // Index of the final byte lane of a word in the packer.
    localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_WORD - 1);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/imem_boot_ctrl_packer.sv
// Big-endian byte-to-word packer. The first byte of a word lands in [31:24].
// An early last byte finishes the word with the unreceived low bytes zero.
module word_packer
    import imem_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    input  logic        i_last,
    output logic [31:0] o_word,
    output logic        o_word_done,
    output logic        o_short
);

    logic [1:0]  r_idx;
    logic [31:0] r_word;
    logic [31:0] w_lane;

    // Place the incoming byte into its lane; completed word includes it.
    always_comb begin
        w_lane = '0;
        case (r_idx)
            2'd0:    w_lane = {i_byte, 24'h000000};
            2'd1:    w_lane = {8'h00, i_byte, 16'h0000};
            2'd2:    w_lane = {16'h0000, i_byte, 8'h00};
            default: w_lane = {24'h000000, i_byte};
        endcase
        o_word      = r_word | w_lane;
        o_word_done = i_accept && ((r_idx == LAST_BYTE_IDX) || i_last);
        o_short     = i_accept && i_last && (r_idx != LAST_BYTE_IDX);
    end

    // Accumulate bytes; restart empty after each finished word or on clear.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_clear) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_accept) begin
            if (o_word_done) begin
                r_idx  <= '0;
                r_word <= '0;
            end else begin
                r_idx  <= r_idx + 2'd1;
                r_word <= o_word;
            end
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot loader and port arbiter for the instruction memory: loads a byte
// image into consecutive words while the CPU is stalled, then hands the
// single memory port to instruction fetch.
module imem_boot_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int unsigned AW = IMEM_AW
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_ld_valid,
    output logic          o_ld_ready,
    input  logic [7:0]    i_ld_data,
    input  logic          i_ld_last,
    input  logic          i_reload,
    input  logic [AW-1:0] i_fetch_addr,
    output logic [31:0]   o_fetch_data,
    output logic          o_fetch_valid,
    output logic          o_cpu_stall,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_we,
    output logic [31:0]   o_mem_wdata,
    input  logic [31:0]   i_mem_rdata,
    output logic [AW:0]   o_words_loaded,
    output logic          o_load_err
);

    localparam logic [AW-1:0] LAST_ADDR = '1;
    localparam logic [AW:0]   ONE_WORD  = (AW + 1)'(1);

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_wr_addr;
    logic [AW:0]   r_words;
    logic          r_err;
    logic          r_we;
    logic          r_finish;
    logic [31:0]   r_wdata;

    logic          w_load;
    logic          w_accept;
    logic [31:0]   w_word;
    logic          w_word_done;
    logic          w_short;

    assign w_load   = (r_state == LOAD);
    // A byte arriving together with reload belongs to the discarded image.
    assign w_accept = w_load && i_ld_valid && !r_we && !i_reload;

    word_packer u_packer (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_clear     (i_reload),
        .i_accept    (w_accept),
        .i_byte      (i_ld_data),
        .i_last      (i_ld_last),
        .o_word      (w_word),
        .o_word_done (w_word_done),
        .o_short     (w_short)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Leave LOAD after the final or the top-of-memory write; reload always returns to LOAD.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LOAD: begin
                if (!i_reload && r_we && (r_finish || (r_wr_addr == LAST_ADDR))) begin
                    w_state_next = RUN;
                end
            end
            default: begin
                if (i_reload) begin
                    w_state_next = LOAD;
                end
            end
        endcase
    end

    // Write pipeline and load counters; a write already on the port completes before reload clears.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_wr_addr <= '0;
            r_words   <= '0;
            r_err     <= 1'b0;
            r_we      <= 1'b0;
            r_finish  <= 1'b0;
            r_wdata   <= '0;
        end else if (i_reload) begin
            r_wr_addr <= '0;
            r_words   <= '0;
            r_err     <= 1'b0;
            r_we      <= 1'b0;
            r_finish  <= 1'b0;
        end else begin
            r_we     <= w_accept && w_word_done;
            r_finish <= w_accept && w_word_done && i_ld_last;
            if (w_accept && w_word_done) begin
                r_wdata <= w_word;
            end
            if (w_short) begin
                r_err <= 1'b1;
            end
            if (r_we) begin
                r_words <= r_words + ONE_WORD;
                if (r_wr_addr != LAST_ADDR) begin
                    r_wr_addr <= r_wr_addr + 1'b1;
                end
            end
        end
    end

    // Port mux and handshake outputs by mode.
    always_comb begin
        o_ld_ready    = 1'b0;
        o_cpu_stall   = 1'b1;
        o_fetch_valid = 1'b0;
        o_fetch_data  = '0;
        o_mem_addr    = r_wr_addr;
        o_mem_we      = 1'b0;
        if (w_load) begin
            o_ld_ready = !r_we;
            o_mem_we   = r_we;
        end else begin
            o_cpu_stall   = 1'b0;
            o_fetch_valid = 1'b1;
            o_fetch_data  = i_mem_rdata;
            o_mem_addr    = i_fetch_addr;
        end
    end

    assign o_mem_wdata    = r_wdata;
    assign o_words_loaded = r_words;
    assign o_load_err     = r_err;

endmodule
